// File: rtl/alu_bus_sequencer.sv
// Host front/back end for the one-hot ALU control unit: command in,
// operand steering onto INBUS, OUTBUS capture, result out, watchdog.
module alu_bus_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_q,
    input  logic [WIDTH-1:0] cmd_m,
    output logic             BEGIN,
    output logic [1:0]       op_code,
    input  logic             loadA_req,
    input  logic             loadQ_req,
    input  logic             loadM_req,
    input  logic             pushA,
    input  logic             pushQ,
    input  logic             END,
    output logic [WIDTH-1:0] inbus,
    input  logic [WIDTH-1:0] outbus,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_q,
    output logic             res_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] op_m;
    logic [WD_W-1:0]  wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            BEGIN     <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            op_code   <= '0;
            res_a     <= '0;
            res_q     <= '0;
            op_a      <= '0;
            op_q      <= '0;
            op_m      <= '0;
            wd        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_code   <= cmd_op;
                        op_a      <= cmd_a;
                        op_q      <= cmd_q;
                        op_m      <= cmd_m;
                        res_a     <= '0;
                        res_q     <= '0;
                        res_err   <= 1'b0;
                        wd        <= '0;
                        cmd_ready <= 1'b0;
                        BEGIN     <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    BEGIN <= 1'b0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (pushA) begin
                        res_a <= outbus;
                    end
                    if (pushQ) begin
                        res_q <= outbus;
                    end
                    wd <= wd + WD_ONE;
                    // END beats a timeout landing in the same cycle
                    if (END) begin
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (wd == WD_LAST) begin
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        inbus = '0;
        priority case (1'b1)
            loadA_req: inbus = op_a;
            loadQ_req: inbus = op_q;
            loadM_req: inbus = op_m;
            default:   inbus = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: plays the control unit and datapath,
// checks handshakes, INBUS steering, captures and the watchdog.
module tb_alu_bus_sequencer;

    localparam int W   = 8;
    localparam int TMO = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_q;
    logic [W-1:0] cmd_m;
    logic         BEGIN;
    logic [1:0]   op_code;
    logic         loadA_req;
    logic         loadQ_req;
    logic         loadM_req;
    logic         pushA;
    logic         pushQ;
    logic         END;
    logic [W-1:0] inbus;
    logic [W-1:0] outbus;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_a;
    logic [W-1:0] res_q;
    logic         res_err;

    int n_chk  = 0;
    int n_fail = 0;

    alu_bus_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_q(cmd_q),
        .cmd_m(cmd_m), .BEGIN(BEGIN), .op_code(op_code),
        .loadA_req(loadA_req), .loadQ_req(loadQ_req),
        .loadM_req(loadM_req), .pushA(pushA), .pushQ(pushQ),
        .END(END), .inbus(inbus), .outbus(outbus),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_a(res_a), .res_q(res_q), .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, q, m;
        bit         end_sep;
        bit         dup;
        int         gap;
        int         bp;
        logic [7:0] exp_a, exp_q;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of each op on (A, Q, M) register contents
    function automatic void ref_model(input logic [1:0] op,
                                      input logic [7:0] a, q, m,
                                      output logic [7:0] ea, eq);
        int unsigned x;
        ea = 8'h00;
        eq = 8'h00;
        case (op)
            2'd0: begin x = 32'(a) + 32'(m); ea = 8'(x); end
            2'd1: begin x = 32'(a) - 32'(m); ea = 8'(x); end
            2'd2: begin
                x  = 32'(q) * 32'(m);
                ea = 8'(x >> 8);
                eq = 8'(x);
            end
            default: begin
                x  = (32'(a) << 8) | 32'(q);
                if (m != 0) begin
                    ea = 8'(x % 32'(m));
                    eq = 8'(x / 32'(m));
                end
            end
        endcase
    endfunction

    task automatic do_load(input int which, input logic [7:0] exp,
                           output logic [7:0] got);
        loadA_req = (which == 0);
        loadQ_req = (which == 1);
        loadM_req = (which == 2);
        #1;
        got = inbus;
        chk("inbus_load", inbus, exp);
        tick();
        loadA_req = 0;
        loadQ_req = 0;
        loadM_req = 0;
    endtask

    task automatic push(input bit is_a, input logic [7:0] v,
                        input bit e);
        pushA  = is_a;
        pushQ  = !is_a;
        outbus = v;
        END    = e;
        tick();
        pushA  = 0;
        pushQ  = 0;
        END    = 0;
        outbus = 8'($urandom);
    endtask

    task automatic accept(input logic [1:0] op,
                          input logic [7:0] a, q, m);
        cmd_op = op; cmd_a = a; cmd_q = q; cmd_m = m;
        cmd_valid = 1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        chk("begin_start", BEGIN, 1);
        chk("op_code_start", op_code, op);
        chk("cmd_ready_busy", cmd_ready, 0);
        tick();
        chk("begin_drop", BEGIN, 0);
    endtask

    task automatic release_res();
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_drop", res_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic run_cmd(input vec_t v);
        logic [7:0] ra, rq, rm, oa, oq;
        bool_end: begin end
        ra = 0; rq = 0; rm = 0;
        accept(v.op, v.a, v.q, v.m);
        case (v.op)
            2'd2: begin
                do_load(1, v.q, rq);
                do_load(2, v.m, rm);
            end
            2'd3: begin
                do_load(0, v.a, ra);
                do_load(1, v.q, rq);
                do_load(2, v.m, rm);
            end
            default: begin
                do_load(0, v.a, ra);
                do_load(2, v.m, rm);
            end
        endcase
        repeat (v.gap) tick();
        ref_model(v.op, ra, rq, rm, oa, oq);
        if (v.dup) push(1, ~oa, 0);
        case (v.op)
            2'd2: begin
                push(1, oa, 0);
                push(0, oq, !v.end_sep);
            end
            2'd3: begin
                push(0, oq, 0);
                push(1, oa, !v.end_sep);
            end
            default: push(1, oa, !v.end_sep);
        endcase
        if (v.end_sep) begin
            END = 1;
            tick();
            END = 0;
        end
        chk("res_valid", res_valid, 1);
        chk("res_a", res_a, v.exp_a);
        chk("res_q", res_q, v.exp_q);
        chk("res_err", res_err, 0);
        chk("cmd_ready_done", cmd_ready, 0);
        chk("op_code_done", op_code, v.op);
        res_ready = 0;
        for (int i = 0; i < v.bp; i++) begin
            cmd_valid = 1;
            cmd_op = 2'($urandom);
            cmd_a = 8'($urandom); cmd_q = 8'($urandom);
            cmd_m = 8'($urandom);
            pushA = 1; pushQ = 1; END = 1;
            outbus = 8'($urandom);
            tick();
            chk("bp_valid", res_valid, 1);
            chk("bp_res_a", res_a, v.exp_a);
            chk("bp_res_q", res_q, v.exp_q);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_begin", BEGIN, 0);
            chk("bp_op_code", op_code, v.op);
        end
        cmd_valid = 0; pushA = 0; pushQ = 0; END = 0;
        release_res();
    endtask

    task automatic run_timeout(input bit end_at_last);
        accept(2'd1, 8'h33, 8'h44, 8'h55);
        for (int k = 1; k <= TMO; k++) begin
            chk("tmo_early", res_valid, 0);
            if (end_at_last && k == TMO) END = 1;
            tick();
            END = 0;
        end
        chk("tmo_valid", res_valid, 1);
        chk("tmo_err", res_err, !end_at_last);
        chk("tmo_res_a", res_a, 0);
        chk("tmo_res_q", res_q, 0);
        release_res();
    endtask

    initial begin
        vec_t rv;
        reset = 1; cmd_valid = 0; cmd_op = 0;
        cmd_a = 0; cmd_q = 0; cmd_m = 0;
        loadA_req = 0; loadQ_req = 0; loadM_req = 0;
        pushA = 0; pushQ = 0; END = 0;
        outbus = 0; res_ready = 0;
        repeat (2) tick();
        reset = 0;

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_begin", BEGIN, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_op_code", op_code, 0);
        chk("rst_res_a", res_a, 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_inbus_idle", inbus, 0);
        loadA_req = 1; loadQ_req = 1; loadM_req = 1;
        #1;
        chk("rst_operands", inbus, 0);
        loadA_req = 0; loadQ_req = 0; loadM_req = 0;

        vecs[0] = '{2'd0, 8'h12, 8'h00, 8'h05, 1, 0, 0, 0,
                    8'h17, 8'h00};
        vecs[1] = '{2'd2, 8'h00, 8'h03, 8'h07, 0, 0, 0, 0,
                    8'h00, 8'h15};
        vecs[2] = '{2'd3, 8'h00, 8'h64, 8'h07, 0, 0, 1, 0,
                    8'h02, 8'h0E};
        vecs[3] = '{2'd1, 8'h05, 8'h99, 8'h07, 1, 1, 0, 0,
                    8'hFE, 8'h00};
        vecs[4] = '{2'd2, 8'h00, 8'hFF, 8'hFF, 1, 1, 2, 0,
                    8'hFE, 8'h01};
        vecs[5] = '{2'd3, 8'h06, 8'hFF, 8'h07, 0, 0, 0, 5,
                    8'h06, 8'hFF};
        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Latched operands of the last command remain on INBUS
        loadA_req = 1; loadM_req = 1; #1;
        chk("prio_a_m", inbus, vecs[5].a);
        loadA_req = 0; loadQ_req = 1; #1;
        chk("prio_q_m", inbus, vecs[5].q);
        loadA_req = 1; #1;
        chk("prio_a_q_m", inbus, vecs[5].a);
        loadA_req = 0; loadQ_req = 0; #1;
        chk("sel_m", inbus, vecs[5].m);
        loadM_req = 0; #1;
        chk("sel_none", inbus, 0);

        run_timeout(0);
        run_timeout(1);

        // Reset in the middle of an operation
        accept(2'd2, 8'h00, 8'h11, 8'h22);
        push(1, 8'h5A, 0);
        chk("mid_res_a", res_a, 8'h5A);
        reset = 1;
        tick();
        reset = 0;
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_res_valid", res_valid, 0);
        chk("mrst_res_a", res_a, 0);
        chk("mrst_op_code", op_code, 0);
        push(1, 8'hAA, 1);
        chk("stray_cmd_ready", cmd_ready, 1);
        chk("stray_res_valid", res_valid, 0);
        chk("stray_res_a", res_a, 0);
        chk("stray_begin", BEGIN, 0);
        tick();
        chk("stray_idle", cmd_ready, 1);

        for (int n = 0; n < 40; n++) begin
            rv.op = 2'($urandom_range(0, 3));
            rv.a = 8'($urandom);
            rv.q = 8'($urandom);
            rv.m = 8'($urandom);
            if (rv.op == 2'd3) begin
                rv.m = 8'($urandom_range(1, 255));
                rv.a = 8'($urandom_range(0, 32'(rv.m) - 1));
            end
            rv.end_sep = 1'($urandom_range(0, 1));
            rv.dup = 1'($urandom_range(0, 1));
            rv.gap = $urandom_range(0, 2);
            rv.bp = $urandom_range(0, 2);
            ref_model(rv.op, rv.a, rv.q, rv.m, rv.exp_a, rv.exp_q);
            run_cmd(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
